// File: rtl/clk_div_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobes.
// Half-periods can be reprogrammed at runtime; a new value is applied at the next half-period boundary.
module clk_div_multi #(
    parameter int NUM_CH       = 3,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 2500
) (
    input  logic                    clk_50Mhz,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync_clear,
    input  logic                    load,
    input  logic [NUM_CH-1:0]       load_mask,
    input  logic [NUM_CH*CNT_W-1:0] half_in,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic                    cfg_err
);

    localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HALF);

    logic [NUM_CH-1:0] zero_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [CNT_W-1:0] slice;
            logic             load_sel;
            logic             load_ok;
            logic             boundary;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] hp_reg;
            logic [CNT_W-1:0] pend_reg;
            logic             pv_reg;
            logic             clk_reg;
            logic             tick_reg;

            assign slice        = half_in[gi*CNT_W +: CNT_W];
            assign load_sel     = load & load_mask[gi];
            assign load_ok      = load_sel && (slice != '0);
            assign zero_sel[gi] = load_sel && (slice == '0);
            // hp is never zero, so hp-1 cannot underflow
            assign boundary     = cnt_reg >= (hp_reg - CNT_W'(1));

            always_ff @(posedge clk_50Mhz) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    hp_reg   <= HP_RST;
                    pend_reg <= '0;
                    pv_reg   <= 1'b0;
                    clk_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else if (sync_clear) begin
                    cnt_reg  <= '0;
                    clk_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                    // A same-cycle load bypasses pending and becomes active directly
                    if (load_ok) begin
                        hp_reg <= slice;
                        pv_reg <= 1'b0;
                    end else if (pv_reg) begin
                        hp_reg <= pend_reg;
                        pv_reg <= 1'b0;
                    end
                end else begin
                    tick_reg <= 1'b0;
                    if (en) begin
                        if (boundary) begin
                            cnt_reg  <= '0;
                            clk_reg  <= ~clk_reg;
                            tick_reg <= ~clk_reg;
                            if (pv_reg) begin
                                hp_reg <= pend_reg;
                                pv_reg <= 1'b0;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    // Placed last so a load coinciding with a boundary stays pending
                    if (load_ok) begin
                        pend_reg <= slice;
                        pv_reg   <= 1'b1;
                    end
                end
            end

            assign clk_out[gi] = clk_reg;
            assign tick[gi]    = tick_reg;
        end
    endgenerate

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= |zero_sel;
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (3 channels, 16-bit counters, default half 2500).
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;

    logic                    clk_50Mhz;
    logic                    rst_n;
    logic                    en;
    logic                    sync_clear;
    logic                    load;
    logic [NUM_CH-1:0]       load_mask;
    logic [NUM_CH*CNT_W-1:0] half_in;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic                    cfg_err;

    int errors = 0;
    int checks = 0;

    clk_div_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_HALF(2500)
    ) dut (
        .clk_50Mhz(clk_50Mhz),
        .rst_n(rst_n),
        .en(en),
        .sync_clear(sync_clear),
        .load(load),
        .load_mask(load_mask),
        .half_in(half_in),
        .clk_out(clk_out),
        .tick(tick),
        .cfg_err(cfg_err)
    );

    initial clk_50Mhz = 1'b0;
    always #10 clk_50Mhz = ~clk_50Mhz;

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        sync_clear = 1'b0;
        load       = 1'b0;
        load_mask  = '0;
        half_in    = '0;

        // Reset state
        step(2);
        $display("step reset: clk_out=%b tick=%b cfg_err=%b", clk_out, tick, cfg_err);
        chk("rst_clk", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_cfg", 32'(cfg_err), 32'h0);

        // 1: defaults, half=2500 on all channels
        rst_n = 1'b1;
        en    = 1'b1;
        step(2499);
        $display("step default 2499: clk_out=%b", clk_out);
        chk("def_low_2499", 32'(clk_out), 32'h0);
        step(1);
        $display("step default 2500: clk_out=%b tick=%b", clk_out, tick);
        chk("def_rise_clk", 32'(clk_out), 32'h7);
        chk("def_rise_tick", 32'(tick), 32'h7);
        step(1);
        chk("def_tick_drop", 32'(tick), 32'h0);
        chk("def_high_hold", 32'(clk_out), 32'h7);
        step(2498);
        chk("def_high_4999", 32'(clk_out), 32'h7);
        step(1);
        $display("step default 5000: clk_out=%b tick=%b", clk_out, tick);
        chk("def_fall_clk", 32'(clk_out), 32'h0);
        chk("def_fall_tick", 32'(tick), 32'h0);
        step(2500);
        $display("step default 7500: clk_out=%b tick=%b", clk_out, tick);
        chk("def_rise2_tick", 32'(tick), 32'h7);

        // 2: ch0 half=1, ch1 half=5, then sync_clear
        load      = 1'b1;
        load_mask = 3'b011;
        half_in   = {16'd0, 16'd5, 16'd1};
        step(1);
        load       = 1'b0;
        load_mask  = '0;
        sync_clear = 1'b1;
        step(1);
        $display("step sync_clear: clk_out=%b tick=%b", clk_out, tick);
        chk("clr_clk", 32'(clk_out), 32'h0);
        chk("clr_tick", 32'(tick), 32'h0);
        sync_clear = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic [1:0] exp_clk;
            logic [1:0] exp_tick;
            step(1);
            exp_clk  = {(k >= 5 && k < 10) ? 1'b1 : 1'b0, (k % 2 == 1) ? 1'b1 : 1'b0};
            exp_tick = {(k == 5) ? 1'b1 : 1'b0, (k % 2 == 1) ? 1'b1 : 1'b0};
            $display("step fast k=%0d: clk_out=%b tick=%b", k, clk_out, tick);
            chk($sformatf("fast_clk_k%0d", k), 32'(clk_out[1:0]), 32'(exp_clk));
            chk($sformatf("fast_tick_k%0d", k), 32'(tick[1:0]), 32'(exp_tick));
        end

        // 3: ch2 hp=10 via load alongside sync_clear, then reload 3 at cnt=4
        load       = 1'b1;
        load_mask  = 3'b100;
        half_in    = {16'd10, 16'd0, 16'd0};
        sync_clear = 1'b1;
        step(1);
        load       = 1'b0;
        load_mask  = '0;
        sync_clear = 1'b0;
        step(4);
        load      = 1'b1;
        load_mask = 3'b100;
        half_in   = {16'd3, 16'd0, 16'd0};
        step(1);
        load      = 1'b0;
        load_mask = '0;
        step(4);
        $display("step reprog C9: clk_out=%b", clk_out);
        chk("reprog_low_c9", 32'(clk_out[2]), 32'h0);
        step(1);
        $display("step reprog C10: clk_out=%b tick=%b", clk_out, tick);
        chk("reprog_rise_c10", 32'(clk_out[2]), 32'h1);
        chk("reprog_tick_c10", 32'(tick[2]), 32'h1);
        step(2);
        chk("reprog_high_c12", 32'(clk_out[2]), 32'h1);
        step(1);
        chk("reprog_fall_c13", 32'(clk_out[2]), 32'h0);
        step(2);
        chk("reprog_low_c15", 32'(clk_out[2]), 32'h0);
        step(1);
        $display("step reprog C16: clk_out=%b tick=%b", clk_out, tick);
        chk("reprog_rise_c16", 32'(clk_out[2]), 32'h1);
        chk("reprog_tick_c16", 32'(tick[2]), 32'h1);

        // 4: zero slice on ch1, 7 on ch0
        chk("cfg_before", 32'(cfg_err), 32'h0);
        load      = 1'b1;
        load_mask = 3'b011;
        half_in   = {16'd9, 16'd0, 16'd7};
        step(1);
        $display("step zero load: cfg_err=%b", cfg_err);
        chk("cfg_pulse", 32'(cfg_err), 32'h1);
        load       = 1'b0;
        load_mask  = '0;
        sync_clear = 1'b1;
        step(1);
        chk("cfg_one_cycle", 32'(cfg_err), 32'h0);
        sync_clear = 1'b0;
        step(5);
        $display("step after zero load E5: clk_out=%b", clk_out);
        chk("hp_e5_clk", 32'(clk_out), 32'h6);
        step(1);
        chk("hp_e6_clk", 32'(clk_out), 32'h2);
        step(1);
        $display("step after zero load E7: clk_out=%b tick=%b", clk_out, tick);
        chk("hp_e7_clk", 32'(clk_out), 32'h3);
        chk("hp_e7_tick", 32'(tick), 32'h1);
        chk("cfg_quiet", 32'(cfg_err), 32'h0);

        // 5: freeze for 100 cycles mid half-period
        step(3);
        en = 1'b0;
        step(1);
        chk("frz_tick_f1", 32'(tick), 32'h0);
        chk("frz_clk_f1", 32'(clk_out), 32'h5);
        step(99);
        $display("step freeze F100: clk_out=%b tick=%b", clk_out, tick);
        chk("frz_clk_f100", 32'(clk_out), 32'h5);
        chk("frz_tick_f100", 32'(tick), 32'h0);
        en = 1'b1;
        step(1);
        chk("res_g1", 32'(clk_out), 32'h5);
        step(1);
        chk("res_g2", 32'(clk_out), 32'h1);
        step(1);
        chk("res_g3", 32'(clk_out), 32'h1);
        step(1);
        $display("step resume G4: clk_out=%b", clk_out);
        chk("res_g4", 32'(clk_out), 32'h0);

        // 6: pending loads, then reset during load+sync_clear
        load      = 1'b1;
        load_mask = 3'b111;
        half_in   = {16'd2, 16'd2, 16'd2};
        step(1);
        rst_n      = 1'b0;
        half_in    = {16'd3, 16'd0, 16'd3};
        sync_clear = 1'b1;
        step(1);
        $display("step reset mid-op: clk_out=%b tick=%b cfg_err=%b", clk_out, tick, cfg_err);
        chk("rst2_clk", 32'(clk_out), 32'h0);
        chk("rst2_tick", 32'(tick), 32'h0);
        chk("rst2_cfg", 32'(cfg_err), 32'h0);
        rst_n     = 1'b1;
        load      = 1'b0;
        load_mask = '0;
        half_in   = '0;
        step(1);
        chk("rst2_clr_clk", 32'(clk_out), 32'h0);
        sync_clear = 1'b0;
        step(2499);
        $display("step post-reset 2499: clk_out=%b", clk_out);
        chk("rst2_low_2499", 32'(clk_out), 32'h0);
        step(1);
        $display("step post-reset 2500: clk_out=%b tick=%b", clk_out, tick);
        chk("rst2_rise_clk", 32'(clk_out), 32'h7);
        chk("rst2_rise_tick", 32'(tick), 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
